// File: rtl/pipeline_stage_reg_if.sv
// Valid/ready stream bundle for one side of a pipeline stage register.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. Once valid is raised, the master holds valid, data and ctrl
// unchanged until that transfer. Ready never depends combinationally on valid.
interface pipeline_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline stage register: a 2-entry skid buffer (main + skid) with
// valid/ready handshake, synchronous flush and occupancy report.
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating stall/bubble
// counters; without it stall_cnt and bubble_cnt are tied to zero.
// Handshake: accept = in.valid & in.ready, pop = out.valid & out.ready.
// in.ready comes from registered state only, so there is no combinational
// path from out.ready to in.ready.
module pipeline_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipeline_stage_reg_if.slave  in_if,
    pipeline_stage_reg_if.master out_if,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              pop;

    // Handshake and output decode from registered state.
    assign in_if.ready  = (state != FULL);
    assign out_if.valid = (state != EMPTY);
    assign out_if.data  = main_data;
    assign out_if.ctrl  = out_if.valid ? main_ctrl : '0;
    assign accept       = in_if.valid & in_if.ready;
    assign pop          = out_if.valid & out_if.ready;
    assign occupancy    = state;
    assign state_dbg    = state;

    // Skid-buffer FSM: main always holds the oldest entry, skid the younger.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            // Kill everything held; the incoming beat is dropped too.
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_if.data;
                        main_ctrl <= in_if.ctrl;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data <= in_if.data;
                        main_ctrl <= in_if.ctrl;
                    end else if (accept) begin
                        skid_data <= in_if.data;
                        skid_ctrl <= in_if.ctrl;
                        state     <= FULL;
                    end else if (pop) begin
                        // Data is left in place; only the sideband is dropped.
                        main_ctrl <= '0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_ctrl <= '0;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] cnt_one;

    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating performance counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_if.valid && !out_if.ready && (stall_q != '1)) begin
                stall_q <= stall_q + cnt_one;
            end
            if (out_if.ready && !out_if.valid && (bubble_q != '1)) begin
                bubble_q <= bubble_q + cnt_one;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: reset, streaming, back-pressure,
// flush in FULL, counter saturation and bubble counting.
module tb_pipeline_stage_reg;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [1:0]        state_dbg;

    int checks;
    int errors;

    pipeline_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipeline_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    pipeline_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_if     (up_if),
        .out_if    (dn_if),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected counter value depending on whether the counters are built.
    function automatic logic [127:0] cexp(input int v);
`ifdef PIPE_PERF_CNT_EN
        return 128'(v);
`else
        return 128'(0 * v);
`endif
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        up_if.valid = v;
        up_if.data  = d;
        up_if.ctrl  = c;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b1, 128'hAA, 8'h05);

        // Reset held for two cycles with a valid beat presented.
        tick();
        tick();
        check("rst_in_ready", up_if.ready, 1);
        check("rst_out_valid", dn_if.valid, 0);
        check("rst_out_ctrl", dn_if.ctrl, 0);
        check("rst_out_data", dn_if.data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_state", state_dbg, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);

        // Bubble count: ready downstream, nothing upstream, 3 cycles.
        reset = 1'b0;
        dn_if.ready = 1'b1;
        drive(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) tick();
        check("bubble_3", bubble_cnt, cexp(3));
        check("bubble_stall0", stall_cnt, 0);
        check("bubble_out_valid", dn_if.valid, 0);

        // Streaming 1..4 with out_ready high (first edge adds one bubble).
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 128'(i), 8'h01);
            tick();
            check($sformatf("stream_data_%0d", i), dn_if.data, 128'(i));
            check($sformatf("stream_ctrl_%0d", i), dn_if.ctrl, 8'h01);
            check($sformatf("stream_occ_%0d", i), occupancy, 1);
            check($sformatf("stream_in_ready_%0d", i), up_if.ready, 1);
        end
        drive(1'b0, '0, '0);
        tick();
        check("drain_out_valid", dn_if.valid, 0);
        check("drain_out_ctrl", dn_if.ctrl, 0);
        check("drain_occ", occupancy, 0);
        check("drain_data_kept", dn_if.data, 4);

        // Back-pressure: 5 then 6 fill the stage, 7 must be refused.
        dn_if.ready = 1'b0;
        drive(1'b1, 128'h5, 8'h22);
        tick();
        check("bp_occ1", occupancy, 1);
        check("bp_data5", dn_if.data, 5);
        drive(1'b1, 128'h6, 8'h33);
        tick();
        check("bp_occ2", occupancy, 2);
        check("bp_in_ready0", up_if.ready, 0);
        check("bp_ctrl22", dn_if.ctrl, 8'h22);
        drive(1'b1, 128'h7, 8'h77);
        tick();
        check("bp_hold_occ", occupancy, 2);
        check("bp_hold_data", dn_if.data, 5);
        tick();
        check("bp_hold_data2", dn_if.data, 5);
        check("bp_stall3", stall_cnt, cexp(3));
        drive(1'b0, '0, '0);
        dn_if.ready = 1'b1;
        tick();
        check("bp_pop_data6", dn_if.data, 6);
        check("bp_pop_ctrl33", dn_if.ctrl, 8'h33);
        check("bp_in_ready1", up_if.ready, 1);
        check("bp_pop_occ1", occupancy, 1);
        tick();
        check("bp_empty", dn_if.valid, 0);
        check("bp_no7", dn_if.data, 6);

        // Flush while FULL with a valid beat offered.
        dn_if.ready = 1'b0;
        drive(1'b1, 128'h5, 8'h44);
        tick();
        drive(1'b1, 128'h6, 8'h66);
        tick();
        check("fl_occ2", occupancy, 2);
        flush = 1'b1;
        drive(1'b1, 128'h9, 8'h55);
        tick();
        check("fl_out_valid", dn_if.valid, 0);
        check("fl_out_ctrl", dn_if.ctrl, 0);
        check("fl_occ0", occupancy, 0);
        check("fl_in_ready", up_if.ready, 1);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        check("fl_no9_valid", dn_if.valid, 0);
        check("fl_no9_data", dn_if.data, 5);
        check("fl_stall5", stall_cnt, cexp(5));

        // Stall saturation at 15 with a 4-bit counter.
        drive(1'b1, 128'hA, 8'h0A);
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall15", stall_cnt, cexp(15));
        check("sat_data_stable", dn_if.data, 128'hA);
        check("sat_ctrl_stable", dn_if.ctrl, 8'h0A);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_after_flush", stall_cnt, cexp(15));
        check("sat_flush_occ", occupancy, 0);
        check("bubble_total4", bubble_cnt, cexp(4));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sat_reset_stall", stall_cnt, 0);
        check("sat_reset_bubble", bubble_cnt, 0);
        check("sat_reset_data", dn_if.data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register; usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a control sideband (regwrite, is_ai, rd and similar). The sideband is forced to zero whenever the stage holds no valid instruction.
- A 2-entry skid buffer with valid/ready handshake replaces the always-load behaviour, giving back-pressure without a combinational ready path. Adds a synchronous flush for branch/trap kill and an occupancy indication.

Parameters:
- DATA_W, 128, payload width in bits (pc, operands, imm, alu_op, register indices).
- CTRL_W, 8, control sideband width; bits cleared on bubble or flush.
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control sideband.
- out_valid  out  1  stage presents a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload of the oldest entry.
- out_ctrl  out  CTRL_W  control of the oldest entry; zero when out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.
- bubble_cnt  out  CNT_W  cycles with out_ready & !out_valid.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding {data, ctrl}. State is one of EMPTY, ONE, FULL.
- Handshake signals:
  - in_ready = (state != FULL), decoded from registered state only; no combinational path from out_ready.
  - accept = in_valid & in_ready; pop = out_valid & out_ready.
  - out_valid = (state != EMPTY).
- Transitions, all with flush=0 and reset=0:
  - EMPTY: accept -> main<=in, go to ONE; otherwise stay EMPTY.
  - ONE: accept & pop -> main<=in, stay ONE. accept & !pop -> skid<=in, go to FULL. !accept & pop -> go to EMPTY. Otherwise hold.
  - FULL: pop -> main<=skid, go to ONE (no accept possible). Otherwise hold.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid when the stage was EMPTY, or when in ONE with a simultaneous pop.
  - Sustained throughput is 1 instruction per cycle with out_ready held high.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Stability: while out_valid & !out_ready, out_data and out_ctrl are held unchanged.
- Masking: out_ctrl = main.ctrl when out_valid, else 0. out_data keeps its last value when EMPTY; downstream must not consume it.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- flush:
  - Next state is EMPTY; main.ctrl and skid.ctrl are cleared.
  - Any in_valid presented in the flush cycle is dropped, even if in_ready=1.
  - A pop in the same cycle still completes downstream, since the sampled value was valid.
  - Counters are not affected.
- reset: same as flush, plus main.data, skid.data and both counters cleared to 0. Reset has priority over flush.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, bubble_cnt=0.
- Reset mid-operation: held entries are discarded without a pop. No partial state survives.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: stall_cnt and bubble_cnt each increment by 1 per qualifying cycle, saturate at 2^CNT_W-1 with no wrap, and clear only on reset.
- Undefined: no counter flops are built; stall_cnt and bubble_cnt are tied to 0.
- The datapath is identical in both builds.

Test Plan:
- Reset check: assert reset for 2 cycles with in_valid=1, in_data=0xAA. Required: in_ready=1, out_valid=0, out_ctrl=0, occupancy=0, counters 0.
- Streaming: out_ready=1; push ctrl=0x01 with data=1,2,3,4 on consecutive cycles. Required: out_data 1,2,3,4 on the next 4 cycles, occupancy=1 throughout, no in_ready drop.
- Back-pressure: out_ready=0; push data=5 then 6. Required: occupancy=2 and in_ready=0, and data=7 is not accepted while in_ready=0. Then raise out_ready. Required: out_data 5 then 6 in order, in_ready returns to 1 one cycle after the first pop.
- Flush in FULL: hold 5 and 6, then assert flush with in_valid=1, data=9. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and 9 never appears.
- Counter saturation (PIPE_PERF_CNT_EN, CNT_W=4): stall for 20 cycles. Required: stall_cnt=15 and held. A flush leaves it at 15; reset clears it to 0.
- Bubble count (PIPE_PERF_CNT_EN): out_ready=1, in_valid=0 for 3 cycles. Required: bubble_cnt=3. Without the macro, both counters read 0.
